// File: rtl/jsp_alu.sv
// jsp_alu: registered ALU for the jspcpu datapath.
//
// Every rising edge the ALU samples lhs_in, rhs_in and operation. It then
// updates its result register and five status flags. Opcode 0 holds all
// state, so the ALU can sit idle between micro-ops. The latched result is
// driven onto the shared bus only while assert_bus is high.
//
// Build option:
//   JSP_ALU_SHIFT_EN  when defined, opcodes E and F are SHL and SHR.
//                     When undefined, E and F act as NOP, flag_lcarry is
//                     tied low, and no shifter is built.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   lhs_in         left operand (WIDTH)
//   rhs_in         right operand (WIDTH)
//   operation      4-bit opcode
//   assert_bus     request to drive the result onto the bus
//   bus_out        result register when assert_bus=1, else zero
//   bus_en         tri-state enable, equal to assert_bus
//   flag_zero      result == 0
//   flag_acarry    arithmetic carry (add) / borrow (subtract)
//   flag_lcarry    bit shifted out by the last shift
//   flag_sign      result MSB
//   flag_overflow  two's-complement overflow
module jsp_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] lhs_in,
    input  logic [WIDTH-1:0] rhs_in,
    input  logic [3:0]       operation,
    input  logic             assert_bus,
    output logic [WIDTH-1:0] bus_out,
    output logic             bus_en,
    output logic             flag_zero,
    output logic             flag_acarry,
    output logic             flag_lcarry,
    output logic             flag_sign,
    output logic             flag_overflow
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PASSL = 4'h1;
    localparam logic [3:0] OP_PASSR = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_ADDC  = 4'h4;
    localparam logic [3:0] OP_INC   = 4'h5;
    localparam logic [3:0] OP_DEC   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_SUBB  = 4'h8;
    localparam logic [3:0] OP_CMP   = 4'h9;
    localparam logic [3:0] OP_AND   = 4'hA;
    localparam logic [3:0] OP_OR    = 4'hB;
    localparam logic [3:0] OP_XOR   = 4'hC;
    localparam logic [3:0] OP_NOT   = 4'hD;
`ifdef JSP_ALU_SHIFT_EN
    localparam logic [3:0] OP_SHL   = 4'hE;
    localparam logic [3:0] OP_SHR   = 4'hF;
`endif

    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] alu_val;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic             cin;
    logic             add_ovf;
    logic             sub_ovf;
    logic             wr_res;
    logic             zs_upd;
    logic             acarry_d;
    logic             ovf_d;
`ifdef JSP_ALU_SHIFT_EN
    logic             lcarry_d;
`endif

    // One adder and one subtractor are shared by all arithmetic opcodes.
    // INC/DEC substitute a constant 1 for the right operand. The carry-in
    // is the flag value registered before this edge, so ADDC/SUBB chains
    // work back to back.
    assign op_b = (operation == OP_INC || operation == OP_DEC) ? WIDTH'(1) : rhs_in;
    assign cin  = (operation == OP_ADDC || operation == OP_SUBB) ? flag_acarry : 1'b0;

    assign add_ext = {1'b0, lhs_in} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    // The extra top bit becomes 1 exactly when the unsigned minuend is
    // smaller than the subtrahend plus the carry-in, i.e. on a borrow.
    assign sub_ext = {1'b0, lhs_in} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};

    assign add_ovf = (lhs_in[MSB] == op_b[MSB]) && (add_ext[MSB] != lhs_in[MSB]);
    assign sub_ovf = (lhs_in[MSB] != op_b[MSB]) && (sub_ext[MSB] != lhs_in[MSB]);

    always_comb begin
        alu_val  = result_q;
        wr_res   = 1'b0;
        zs_upd   = 1'b0;
        acarry_d = flag_acarry;
        ovf_d    = flag_overflow;
`ifdef JSP_ALU_SHIFT_EN
        lcarry_d = flag_lcarry;
`endif
        case (operation)
            OP_NOP: ;
            OP_PASSL: begin
                alu_val = lhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
            OP_PASSR: begin
                alu_val = rhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
            OP_ADD, OP_ADDC, OP_INC: begin
                alu_val  = add_ext[MSB:0];
                wr_res   = 1'b1;
                zs_upd   = 1'b1;
                acarry_d = add_ext[WIDTH];
                ovf_d    = add_ovf;
            end
            OP_DEC, OP_SUB, OP_SUBB: begin
                alu_val  = sub_ext[MSB:0];
                wr_res   = 1'b1;
                zs_upd   = 1'b1;
                acarry_d = sub_ext[WIDTH];
                ovf_d    = sub_ovf;
            end
            OP_CMP: begin
                // Flags come from the difference, but the result register keeps its value.
                alu_val  = sub_ext[MSB:0];
                zs_upd   = 1'b1;
                acarry_d = sub_ext[WIDTH];
                ovf_d    = sub_ovf;
            end
            OP_AND: begin
                alu_val = lhs_in & rhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
            OP_OR: begin
                alu_val = lhs_in | rhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
            OP_XOR: begin
                alu_val = lhs_in ^ rhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
            OP_NOT: begin
                alu_val = ~lhs_in;
                wr_res  = 1'b1;
                zs_upd  = 1'b1;
                ovf_d   = 1'b0;
            end
`ifdef JSP_ALU_SHIFT_EN
            OP_SHL: begin
                alu_val  = {lhs_in[MSB-1:0], 1'b0};
                wr_res   = 1'b1;
                zs_upd   = 1'b1;
                ovf_d    = 1'b0;
                lcarry_d = lhs_in[MSB];
            end
            OP_SHR: begin
                alu_val  = {1'b0, lhs_in[MSB:1]};
                wr_res   = 1'b1;
                zs_upd   = 1'b1;
                ovf_d    = 1'b0;
                lcarry_d = lhs_in[0];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q      <= '0;
            flag_zero     <= 1'b0;
            flag_acarry   <= 1'b0;
            flag_sign     <= 1'b0;
            flag_overflow <= 1'b0;
        end else begin
            if (wr_res) begin
                result_q <= alu_val;
            end
            if (zs_upd) begin
                flag_zero <= (alu_val == '0);
                flag_sign <= alu_val[MSB];
            end
            flag_acarry   <= acarry_d;
            flag_overflow <= ovf_d;
        end
    end

`ifdef JSP_ALU_SHIFT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_lcarry <= 1'b0;
        end else begin
            flag_lcarry <= lcarry_d;
        end
    end
`else
    assign flag_lcarry = 1'b0;
`endif

    assign bus_en  = assert_bus;
    assign bus_out = assert_bus ? result_q : '0;

endmodule

// File: tb/tb_jsp_alu.sv
// Testbench for jsp_alu (WIDTH = 8). The reference model works on integers:
// it tracks unsigned and signed sums and checks their ranges to find carry,
// borrow and overflow.
module tb_jsp_alu;

    localparam int W = 8;
    localparam int M = 256;
`ifdef JSP_ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] lhs_in = '0;
    logic [W-1:0] rhs_in = '0;
    logic [3:0]   operation = 4'h0;
    logic         assert_bus = 1'b1;
    logic [W-1:0] bus_out;
    logic         bus_en;
    logic         flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow;

    jsp_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .lhs_in(lhs_in),
        .rhs_in(rhs_in),
        .operation(operation),
        .assert_bus(assert_bus),
        .bus_out(bus_out),
        .bus_en(bus_en),
        .flag_zero(flag_zero),
        .flag_acarry(flag_acarry),
        .flag_lcarry(flag_lcarry),
        .flag_sign(flag_sign),
        .flag_overflow(flag_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bus;
        int en;
        int z;
        int ac;
        int lc;
        int s;
        int ov;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;

    // Architectural state of the reference model.
    int m_res = 0, m_z = 0, m_ac = 0, m_lc = 0, m_s = 0, m_ov = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int op, input int l, input int r);
        int  sl, sb, b, c, full, sfull, val;
        bit  wr, upd;
        wr  = 1'b0;
        upd = 1'b1;
        val = m_res;
        sl  = (l >= 128) ? l - 256 : l;
        case (op)
            0: upd = 1'b0;
            1: begin val = l; wr = 1'b1; m_ov = 0; end
            2: begin val = r; wr = 1'b1; m_ov = 0; end
            3, 4, 5: begin
                b     = (op == 5) ? 1 : r;
                c     = (op == 4) ? m_ac : 0;
                sb    = (b >= 128) ? b - 256 : b;
                full  = l + b + c;
                sfull = sl + sb + c;
                val   = full % M;
                m_ac  = (full >= M) ? 1 : 0;
                m_ov  = (sfull > 127 || sfull < -128) ? 1 : 0;
                wr    = 1'b1;
            end
            6, 7, 8, 9: begin
                b     = (op == 6) ? 1 : r;
                c     = (op == 8) ? m_ac : 0;
                sb    = (b >= 128) ? b - 256 : b;
                full  = l - b - c;
                sfull = sl - sb - c;
                val   = (full + M) % M;
                m_ac  = (full < 0) ? 1 : 0;
                m_ov  = (sfull > 127 || sfull < -128) ? 1 : 0;
                wr    = (op != 9);
            end
            10: begin val = l & r; wr = 1'b1; m_ov = 0; end
            11: begin val = l | r; wr = 1'b1; m_ov = 0; end
            12: begin val = l ^ r; wr = 1'b1; m_ov = 0; end
            13: begin val = 255 - l; wr = 1'b1; m_ov = 0; end
            14: begin
                if (SHIFT_EN) begin
                    val = (l * 2) % M; m_lc = l / 128; m_ov = 0; wr = 1'b1;
                end else begin
                    upd = 1'b0;
                end
            end
            default: begin
                if (SHIFT_EN) begin
                    val = l / 2; m_lc = l % 2; m_ov = 0; wr = 1'b1;
                end else begin
                    upd = 1'b0;
                end
            end
        endcase
        if (wr) m_res = val;
        if (upd) begin
            m_z = (val == 0) ? 1 : 0;
            m_s = (val >= 128) ? 1 : 0;
        end
    endtask

    task automatic issue(input int op, input int l, input int r, input bit ab);
        exp_t e;
        @(negedge clk);
        operation  = 4'(op);
        lhs_in     = 8'(l);
        rhs_in     = 8'(r);
        assert_bus = ab;
        model_step(op, l, r);
        e.bus = ab ? m_res : 0;
        e.en  = ab;
        e.z   = m_z;
        e.ac  = m_ac;
        e.lc  = m_lc;
        e.s   = m_s;
        e.ov  = m_ov;
        sb_q.push_back(e);
    endtask

    // Independent spot checks against hand-computed values.
    task automatic expect_now(input string name, input int bus, input int z, input int ac,
                              input int s, input int ov);
        @(posedge clk);
        #2;
        chk({name, ".bus"}, int'(bus_out), bus);
        chk({name, ".zero"}, int'(flag_zero), z);
        chk({name, ".acarry"}, int'(flag_acarry), ac);
        chk({name, ".sign"}, int'(flag_sign), s);
        chk({name, ".overflow"}, int'(flag_overflow), ov);
    endtask

    // Scoreboard monitor: one expected entry per issued cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb.bus_out", int'(bus_out), e.bus);
                chk("sb.bus_en", int'(bus_en), e.en);
                chk("sb.zero", int'(flag_zero), e.z);
                chk("sb.acarry", int'(flag_acarry), e.ac);
                chk("sb.lcarry", int'(flag_lcarry), e.lc);
                chk("sb.sign", int'(flag_sign), e.s);
                chk("sb.overflow", int'(flag_overflow), e.ov);
            end
        end
    end

    initial begin
        int n;
        #1;
        chk("reset.bus_out", int'(bus_out), 0);
        chk("reset.bus_en", int'(bus_en), 1);
        chk("reset.flags", int'({flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        issue(4'hA, 8'h55, 8'hAA, 1'b1);
        expect_now("and", 8'h00, 1, 0, 0, 0);
        issue(4'hB, 8'h55, 8'hAA, 1'b1);
        issue(4'h0, 8'h12, 8'h34, 1'b1);
        issue(4'h0, 8'h00, 8'h00, 1'b1);
        expect_now("or_hold", 8'hFF, 0, 0, 1, 0);
        #1;
        assert_bus = 1'b0;
        #1;
        chk("toggle0.bus_out", int'(bus_out), 0);
        chk("toggle0.bus_en", int'(bus_en), 0);
        assert_bus = 1'b1;
        #1;
        chk("toggle1.bus_out", int'(bus_out), 8'hFF);
        chk("toggle1.bus_en", int'(bus_en), 1);

        issue(4'h3, 200, 64, 1'b1);
        expect_now("add", 8'h08, 0, 1, 0, 0);
        issue(4'h4, 0, 0, 1'b1);
        expect_now("addc1", 8'h01, 0, 0, 0, 0);
        issue(4'h4, 0, 0, 1'b1);
        expect_now("addc2", 8'h00, 1, 0, 0, 0);
        issue(4'h7, 8'h01, 8'h81, 1'b1);
        expect_now("sub", 8'h80, 0, 1, 1, 1);
        issue(4'hE, 8'h81, 8'h00, 1'b1);
        issue(4'hF, 8'h01, 8'h00, 1'b1);
        issue(4'h9, 8'h10, 8'h20, 1'b0);
        issue(4'h2, 8'h7F, 8'h80, 1'b1);

        n = 0;
        while (sb_q.size() > 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain1", sb_q.size(), 0);
        sb_q.delete();

        // Asynchronous reset in the middle of an ADD cycle.
        @(negedge clk);
        operation  = 4'h3;
        lhs_in     = 8'h90;
        rhs_in     = 8'h90;
        assert_bus = 1'b1;
        expect_now("pre_reset", 8'h20, 0, 1, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset.bus_out", int'(bus_out), 0);
        chk("async_reset.bus_en", int'(bus_en), 1);
        chk("async_reset.flags", int'({flag_zero, flag_acarry, flag_lcarry, flag_sign, flag_overflow}), 0);
        @(negedge clk);
        operation = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        m_res = 0; m_z = 0; m_ac = 0; m_lc = 0; m_s = 0; m_ov = 0;

        for (int i = 0; i < 400; i++) begin
            issue(int'($urandom_range(15, 0)), int'($urandom_range(255, 0)),
                  int'($urandom_range(255, 0)), ($urandom_range(3, 0) != 0));
        end

        n = 0;
        while (sb_q.size() > 0 && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("drain2", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jsp_alu.md
# jsp_alu

Parameterised registered ALU for the jspcpu datapath. Each clock it takes two operands (`lhs_in`, `rhs_in`) and a 4-bit opcode, and latches the result and five status flags. It drives the latched result onto the shared data bus only when `assert_bus` is high. Opcode 0 is a no-op that holds all state, so the control unit can leave the ALU idle between micro-ops.

## Interface
- `WIDTH`, default 8: operand, result and bus width (minimum 2).
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `lhs_in`  in  WIDTH: left operand.
- `rhs_in`  in  WIDTH: right operand.
- `operation`  in  4: opcode (see Operation).
- `assert_bus`  in  1: request to drive the result onto the bus.
- `bus_out`  out  WIDTH: registered result when `assert_bus`=1, else all zeros.
- `bus_en`  out  1: equals `assert_bus` (combinational); bus tri-state enable.
- `flag_zero`  out  1: result == 0.
- `flag_acarry`  out  1: arithmetic carry out (add) or borrow (subtract).
- `flag_lcarry`  out  1: logical carry, the bit shifted out.
- `flag_sign`  out  1: result MSB.
- `flag_overflow`  out  1: two's-complement overflow.

## Operation
Opcode map (L = `lhs_in`, R = `rhs_in`, C = current `flag_acarry`):
- 0 NOP: result and all flags held.
- 1 PASSL: L.
- 2 PASSR: R.
- 3 ADD: L+R.
- 4 ADDC: L+R+C.
- 5 INC: L+1.
- 6 DEC: L−1.
- 7 SUB: L−R.
- 8 SUBB: L−R−C.
- 9 CMP: computes L−R; flags updated; result register held.
- A AND: L&R.
- B OR: L|R.
- C XOR: L^R.
- D NOT: ~L.
- E SHL: L<<1; `flag_lcarry` = L[WIDTH-1].
- F SHR: logical L>>1; `flag_lcarry` = L[0].

Rules:
- Arithmetic uses a (WIDTH+1)-bit sum. The result is the low WIDTH bits; wrap-around is modulo 2^WIDTH.
- Add-type ops (3, 4, 5): `flag_acarry` = carry out of bit WIDTH-1.
- Subtract-type ops (6, 7, 8, 9): `flag_acarry` = 1 when a borrow occurs, i.e. unsigned minuend < subtrahend (+C for SUBB).
- `flag_overflow` is set on operands of the same sign producing a result of opposite sign (add), or operands of differing sign where the result sign differs from L (subtract).
- Logic ops (A–D) and PASS ops (1, 2) clear `flag_overflow` and hold `flag_acarry`.
- Shifts hold `flag_acarry` and clear `flag_overflow`.
- `flag_lcarry` changes only on shifts.
- `flag_zero` and `flag_sign` are updated from the new result for every opcode except 0. For CMP they come from the difference.

## Timing
- Single-cycle latency. Operands and opcode are sampled at the rising edge, and the result and flags are visible after that edge.
- ADDC/SUBB use the `flag_acarry` value registered before the sampling edge, so back-to-back ADDC chains correctly.
- `bus_out` and `bus_en` are combinational from `assert_bus` and the result register. There is no added latency.
- Reset (asynchronous, any time, including mid-sequence):
  - result register = 0; all five flags = 0.
  - `bus_out` = 0 unless `assert_bus` is high, in which case it drives 0.
  - Release is synchronous to the next edge.
- An opcode held for several cycles re-executes every cycle. For example, ADDC re-accumulates carry.

## Configuration
- `JSP_ALU_SHIFT_EN` defined: opcodes E and F perform SHL/SHR as above.
- `JSP_ALU_SHIFT_EN` not defined: E and F behave as NOP (opcode 0), `flag_lcarry` is tied to 0, and the shifter logic is not synthesised.

## Test plan
- AND, L=0x55, R=0xAA -> result 0x00; zero=1, sign=0, overflow=0.
- OR, L=0x55, R=0xAA, then opcode 0 for 2 cycles -> result 0xFF; sign=1, zero=0; values held through the NOPs.
- ADD 200+64 -> 0x08, acarry=1, overflow=0. Then ADDC 0+0 -> 0x01, acarry=0. Then ADDC 0+0 -> 0x00, zero=1.
- SUB, L=0x01, R=0x81 -> 0x80; acarry (borrow)=1, overflow=1, sign=1, zero=0.
- With `JSP_ALU_SHIFT_EN`: SHL 0x81 -> 0x02, lcarry=1; SHR 0x01 -> 0x00, lcarry=1, zero=1. Without the macro: result unchanged.
- `assert_bus` toggling -> `bus_en` follows in the same cycle, and `bus_out` alternates between the result and 0x00. Asserting `rst_n` low mid-ADD clears the result and flags immediately, without waiting for a clock edge.
